pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Input-capture peripheral that measures an external PWM waveform. It reports period and high time in clk cycles, plus per-edge event pulses.
- It is the receiving counterpart of the PWM compare/output channels, for measuring duty and frequency on a GPIO input.
- Wishbone-facing registers live in the enclosing PWM peripheral; this block exposes raw capture results only.

Parameters:
- WIDTH, 16, width of the internal counter and the captured values.
- SYNC_STAGES, 2, number of flip-flops in the pwm_in synchroniser (minimum 2).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- enable  input  1  capture enable.
- pwm_in  input  1  asynchronous PWM input pin.
- clearOverflow  input  1  single-cycle pulse that clears overflow.
- period  output  WIDTH  last complete period, in clk cycles (rise to rise).
- highTime  output  WIDTH  high time of that same period, in clk cycles (rise to fall).
- captureValid  output  1  one-cycle pulse when period and highTime update.
- overflow  output  1  sticky flag: counter saturated before the next rising edge.
- riseEvent  output  1  one-cycle pulse per detected rising edge.
- fallEvent  output  1  one-cycle pulse per detected falling edge.

Behaviour:
- Reset (rst low, asynchronous): all registers and outputs go to 0, the synchroniser clears to 0, state goes to IDLE.
- Synchroniser:
  - pwm_in passes through SYNC_STAGES flops to give s.
  - sPrev is s delayed by one cycle.
  - rise = s & !sPrev; fall = !s & sPrev.
  - Synchroniser and sPrev run regardless of enable, so enabling never creates a false edge.
- Edge pulses: riseEvent and fallEvent are the registered rise and fall, gated by enable. Latency from a pwm_in transition to the pulse is SYNC_STAGES+1 cycles.
- Counter cnt (WIDTH bits):
  - Loads 1 in the cycle after a rise is accepted.
  - Otherwise increments by 1 each cycle in HIGH or LOW.
  - Saturates at all-ones and never wraps.
- State machine:
  - IDLE: cnt=0. On enable & rise, go to HIGH (cnt<=1). No capture; the first edge only arms the block.
  - HIGH:
    - On fall: hiLatch<=cnt, go to LOW.
    - On rise (fall was missed): treat as LOW-state rise with hiLatch=cnt.
  - LOW: on rise, period<=cnt, highTime<=hiLatch, captureValid pulses next cycle, cnt<=1, go to HIGH.
- Result: a waveform with N-cycle period and H-cycle high time captures period=N, highTime=H.
- Overflow:
  - If cnt reaches all-ones in HIGH or LOW, overflow<=1 and state goes to IDLE.
  - The next rise re-arms without a capture.
  - 0% and 100% duty inputs therefore end in overflow.
- clearOverflow clears the flag. If set and clear occur in the same cycle, set wins.
- Disable: enable low forces IDLE, cnt<=0, captureValid=0. period, highTime and overflow hold their values. Re-enabling requires a new rise to arm.
- period and highTime change only together, in the cycle captureValid is high, and hold otherwise.
- Minimum measurable: highTime=1 and low time=1, giving period=2. Edges shorter than one clk are not guaranteed.

Test Plan:
- Reset mid-capture: deassert rst, enable=1, drive 100-cycle period with 30 cycles high for 3 periods, then assert rst → first rise gives no captureValid; later captures give period=100, highTime=30; after rst all outputs are 0 and state is IDLE.
- Duty change: switch to 100-cycle period with 70 cycles high → the capture after the switch reports period=100, highTime=70, with exactly one captureValid per period.
- Overflow with WIDTH=8: hold pwm_in high for 300 cycles → overflow=1 and no captureValid. Then run a 50-cycle period with 10 cycles high → first rise re-arms only, second rise captures period=50, highTime=10. Pulse clearOverflow → overflow=0.
- Set/clear collision: clearOverflow asserted in the same cycle cnt saturates → overflow=1.
- Minimum pulse: alternate 1 cycle high / 1 cycle low → period=2, highTime=1; riseEvent and fallEvent each pulse every 2 cycles; latency is SYNC_STAGES+1 cycles.
- Enable gating: drop enable for 20 cycles mid-period while pwm_in toggles → no event pulses and period/highTime hold. After re-enable the first rise only arms; the next rise captures correctly.

Source files
------------

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
//
// Input-capture block that measures an external PWM waveform. It reports the
// last complete period (rise to rise) and its high time (rise to fall) in clk
// cycles, together with per-edge event pulses. Register access lives in the
// enclosing PWM peripheral; this block only exposes raw capture results.
//
// Parameters
//   WIDTH         width of the internal counter and captured values
//   SYNC_STAGES   flops in the pwm_in synchroniser (2 or more)
//
// Ports
//   clk            system clock
//   rst            asynchronous reset, active low
//   enable         capture enable
//   pwm_in         asynchronous PWM input pin
//   clearOverflow  single-cycle pulse that clears the overflow flag
//   period         last complete period in clk cycles
//   highTime       high time of that same period in clk cycles
//   captureValid   one-cycle pulse when period/highTime update
//   overflow       sticky flag: counter saturated before the next rise
//   riseEvent      one-cycle pulse per detected rising edge
//   fallEvent      one-cycle pulse per detected falling edge
// -----------------------------------------------------------------------------
module pwm_capture #(
   parameter int WIDTH       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             pwm_in,
   input  logic             clearOverflow,
   output logic [WIDTH-1:0] period,
   output logic [WIDTH-1:0] highTime,
   output logic             captureValid,
   output logic             overflow,
   output logic             riseEvent,
   output logic             fallEvent
);

   localparam logic [WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
   localparam logic [WIDTH-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic                   s_prev;
   logic                   rise;
   logic                   fall;
   logic                   ovf_set;
   state_t                 state;
   logic [WIDTH-1:0]       cnt;
   logic [WIDTH-1:0]       hi_latch;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // ---- Stage: input synchroniser and edge history --------------------------
   // Runs regardless of enable so that enabling never fabricates an edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         s_prev <= s;
      end
   end

   assign s    = sync_q[SYNC_STAGES-1];
   assign rise = s & ~s_prev;
   assign fall = ~s & s_prev;

   // A rise in the same cycle as saturation still completes the measurement,
   // so saturation only counts when no rise is being accepted.
   assign ovf_set = enable && (state != IDLE) && !rise && (cnt == CNT_MAX);

   // ---- Stage: measurement state machine and registered outputs -------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         cnt          <= CNT_ZERO;
         hi_latch     <= CNT_ZERO;
         period       <= CNT_ZERO;
         highTime     <= CNT_ZERO;
         captureValid <= 1'b0;
         overflow     <= 1'b0;
         riseEvent    <= 1'b0;
         fallEvent    <= 1'b0;
      end else begin
         riseEvent    <= rise & enable;
         fallEvent    <= fall & enable;
         captureValid <= 1'b0;

         // Set has priority over a coincident clear.
         if (ovf_set) begin
            overflow <= 1'b1;
         end else if (clearOverflow) begin
            overflow <= 1'b0;
         end

         if (!enable) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
         end else begin
            case (state)
               IDLE: begin
                  // First rise only arms; there is no reference edge yet.
                  cnt <= CNT_ZERO;
                  if (rise) begin
                     state <= HIGH;
                     cnt   <= CNT_ONE;
                  end
               end
               HIGH: begin
                  if (rise) begin
                     // Falling edge was missed: the whole period counts as high.
                     period       <= cnt;
                     highTime     <= cnt;
                     hi_latch     <= cnt;
                     captureValid <= 1'b1;
                     cnt          <= CNT_ONE;
                  end else if (ovf_set) begin
                     state <= IDLE;
                     cnt   <= CNT_ZERO;
                  end else if (fall) begin
                     hi_latch <= cnt;
                     state    <= LOW;
                     cnt      <= sat_inc(cnt);
                  end else begin
                     cnt <= sat_inc(cnt);
                  end
               end
               LOW: begin
                  if (rise) begin
                     period       <= cnt;
                     highTime     <= hi_latch;
                     captureValid <= 1'b1;
                     cnt          <= CNT_ONE;
                     state        <= HIGH;
                  end else if (ovf_set) begin
                     state <= IDLE;
                     cnt   <= CNT_ZERO;
                  end else begin
                     cnt <= sat_inc(cnt);
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= CNT_ZERO;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pwm_capture
//
// Directed testbench for pwm_capture (WIDTH=8 so saturation is reachable in a
// few hundred cycles). Inputs are driven on the falling clock edge; outputs
// are compared on the falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_capture;

   localparam int W  = 8;
   localparam int SS = 2;

   logic         clk;
   logic         rst;
   logic         enable;
   logic         pwm_in;
   logic         clearOverflow;
   logic [W-1:0] period;
   logic [W-1:0] highTime;
   logic         captureValid;
   logic         overflow;
   logic         riseEvent;
   logic         fallEvent;

   int checks;
   int errors;
   int cap_cnt;
   int rise_cnt;
   int fall_cnt;
   int cyc;
   int last_cap_cyc;
   int cap_gap;
   int c0;
   int r0;
   int f0;

   pwm_capture #(
      .WIDTH       (W),
      .SYNC_STAGES (SS)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enable        (enable),
      .pwm_in        (pwm_in),
      .clearOverflow (clearOverflow),
      .period        (period),
      .highTime      (highTime),
      .captureValid  (captureValid),
      .overflow      (overflow),
      .riseEvent     (riseEvent),
      .fallEvent     (fallEvent)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      cap_cnt      = 0;
      rise_cnt     = 0;
      fall_cnt     = 0;
      last_cap_cyc = 0;
      cap_gap      = 0;
   end

   // Event bookkeeping; the stimulus process reads these 1 time unit later.
   always @(negedge clk) begin
      if (captureValid) begin
         cap_cnt      = cap_cnt + 1;
         cap_gap      = cyc - last_cap_cyc;
         last_cap_cyc = cyc;
      end
      if (riseEvent) rise_cnt = rise_cnt + 1;
      if (fallEvent) fall_cnt = fall_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      assert (obs === exp)
      else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_period"},   32'(period),       0);
      chk({tag, "_hightime"}, 32'(highTime),     0);
      chk({tag, "_capvld"},   32'(captureValid), 0);
      chk({tag, "_ovf"},      32'(overflow),     0);
      chk({tag, "_rise"},     32'(riseEvent),    0);
      chk({tag, "_fall"},     32'(fallEvent),    0);
   endtask

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic wave(input int n, input int h, input int reps);
      for (int i = 0; i < reps; i++) begin
         hold(1'b1, h);
         hold(1'b0, n - h);
      end
   endtask

   task automatic do_reset();
      rst           = 1'b0;
      enable        = 1'b0;
      pwm_in        = 1'b0;
      clearOverflow = 1'b0;
      repeat (3) @(negedge clk);
      rst    = 1'b1;
      enable = 1'b1;
      hold(1'b0, 5);
   endtask

   task automatic snap();
      #1;
      c0 = cap_cnt;
      r0 = rise_cnt;
      f0 = fall_cnt;
   endtask

   initial begin
      logic exp_r;
      logic exp_f;
      logic exp_c;
      checks        = 0;
      errors        = 0;
      rst           = 1'b0;
      enable        = 1'b0;
      pwm_in        = 1'b0;
      clearOverflow = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("reset");

      // ---- Reset mid-capture: 100-cycle period, 30 high ---------------------
      rst    = 1'b1;
      enable = 1'b1;
      hold(1'b0, 5);
      snap();
      hold(1'b1, 30);
      #1;
      chk("arm_no_capture", cap_cnt - c0, 0);
      chk("arm_rise_seen", rise_cnt - r0, 1);
      hold(1'b0, 70);
      wave(100, 30, 2);
      #1;
      chk("p100_caps", cap_cnt - c0, 2);
      chk("p100_rises", rise_cnt - r0, 3);
      chk("p100_falls", fall_cnt - f0, 3);
      chk("p100_period", 32'(period), 100);
      chk("p100_high", 32'(highTime), 30);
      hold(1'b1, 30);
      hold(1'b0, 20);
      #2;
      rst = 1'b0;
      #1;
      chk_zero("async_rst");

      // ---- Duty change 30 -> 70 ----------------------------------------------
      do_reset();
      snap();
      wave(100, 30, 2);
      wave(100, 70, 2);
      #1;
      chk("duty_caps", cap_cnt - c0, 3);
      chk("duty_gap", cap_gap, 100);
      chk("duty_period", 32'(period), 100);
      chk("duty_high", 32'(highTime), 70);

      // ---- Overflow: held high, then re-arm and capture ----------------------
      do_reset();
      snap();
      hold(1'b1, 300);
      #1;
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_no_cap", cap_cnt - c0, 0);
      hold(1'b0, 20);
      wave(50, 10, 2);
      #1;
      chk("rearm_caps", cap_cnt - c0, 1);
      chk("rearm_period", 32'(period), 50);
      chk("rearm_high", 32'(highTime), 10);
      chk("ovf_sticky", 32'(overflow), 1);
      clearOverflow = 1'b1;
      @(negedge clk);
      clearOverflow = 1'b0;
      chk("ovf_cleared", 32'(overflow), 0);

      // ---- Set/clear collision on the saturating cycle -----------------------
      // Rise accepted 3 edges after the drive (cnt=1), cnt=255 after edge 257,
      // flag sets on edge 258.
      do_reset();
      pwm_in = 1'b1;
      repeat (257) @(negedge clk);
      chk("collide_pre", 32'(overflow), 0);
      clearOverflow = 1'b1;
      @(negedge clk);
      clearOverflow = 1'b0;
      chk("collide_set_wins", 32'(overflow), 1);

      // ---- Minimum pulse: 1 high / 1 low, plus edge latency ------------------
      do_reset();
      for (int k = 0; k <= 20; k++) begin
         if (k > 0) begin
            @(negedge clk);
            exp_r = (k >= 3) && (k % 2 == 1);
            exp_f = (k >= 4) && (k % 2 == 0);
            exp_c = (k >= 5) && (k % 2 == 1);
            chk($sformatf("min_rise_%0d", k), 32'(riseEvent), 32'(exp_r));
            chk($sformatf("min_fall_%0d", k), 32'(fallEvent), 32'(exp_f));
            chk($sformatf("min_cap_%0d", k), 32'(captureValid), 32'(exp_c));
         end
         pwm_in = (k % 2 == 0);
      end
      chk("min_period", 32'(period), 2);
      chk("min_high", 32'(highTime), 1);

      // ---- Enable gating ------------------------------------------------------
      do_reset();
      wave(40, 10, 3);
      hold(1'b1, 10);
      hold(1'b0, 10);
      snap();
      chk("gate_pre_period", 32'(period), 40);
      chk("gate_pre_high", 32'(highTime), 10);
      enable = 1'b0;
      hold(1'b1, 5);
      hold(1'b0, 5);
      hold(1'b1, 5);
      hold(1'b0, 5);
      #1;
      chk("gate_no_rise", rise_cnt - r0, 0);
      chk("gate_no_fall", fall_cnt - f0, 0);
      chk("gate_no_cap", cap_cnt - c0, 0);
      chk("gate_hold_period", 32'(period), 40);
      chk("gate_hold_high", 32'(highTime), 10);
      enable = 1'b1;
      hold(1'b0, 5);
      wave(40, 15, 2);
      #1;
      chk("regate_caps", cap_cnt - c0, 1);
      chk("regate_period", 32'(period), 40);
      chk("regate_high", 32'(highTime), 15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
